// File: rtl/reset_gen_pkg.sv
// reset_gen_pkg
// Shared definitions for the reset generator: FSM state encoding and the
// reset-cause encoding reported on rst_cause.
package reset_gen_pkg;

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,  // waiting for the synchronizer chain to fill
    S_HOLD   = 2'd1,  // counting out the hold period, reset_n still low
    S_RUN    = 2'd2   // reset released
  } state_t;

  localparam logic CAUSE_HW = 1'b0;
  localparam logic CAUSE_SW = 1'b1;

endpackage

// File: rtl/reset_sync_chain.sv
// reset_sync_chain
// Shifts a constant 1 through SYNC_STAGES flops so that the release of the
// asynchronous reset reaches the FSM only after it has been resynchronized
// to clk. All stages clear asynchronously while reset is high.
// Ports:
//   clk     - clock
//   reset   - asynchronous, active-high reset
//   sync_ok - last chain stage; 1 once reset has been released and synced
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign chain_d[gi] = 1'b1;
      end else begin : g_rest
        assign chain_d[gi] = chain_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_ok = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_gen_sync.sv
// reset_gen_sync
// Generates the synchronous active-low reset_n for the datapath registers.
// reset_n drops asynchronously with the board reset and rises synchronously
// to clk after the synchronizer chain plus HOLD_CYCLES cycles. A software
// request re-asserts reset_n for exactly HOLD_CYCLES cycles.
// Ports:
//   clk        - clock for all flops
//   reset      - asynchronous, active-high board reset
//   sw_rst_req - software reset request, sampled each rising edge
//   reset_n    - registered active-low reset for downstream logic
//   rst_active - registered, equals ~reset_n
//   rst_done   - one-cycle pulse following the edge where reset_n rises
//   rst_cause  - cause of the last reset (0 = hardware, 1 = software)
module reset_gen_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_rst_req,
  output logic reset_n,
  output logic rst_active,
  output logic rst_done,
  output logic rst_cause
);

  import reset_gen_pkg::*;

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync_ok;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reset_n_q, reset_n_d;
  logic             rst_active_q, rst_active_d;
  logic             rst_done_q, rst_done_d;
  logic             rst_cause_q, rst_cause_d;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sync_ok(sync_ok)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reset_n_d   = reset_n_q;
    rst_done_d  = 1'b0;
    rst_cause_d = rst_cause_q;

    case (state_q)
      S_ASSERT: begin
        // Software requests are ignored here: hardware reset is in charge.
        reset_n_d = 1'b0;
        if (sync_ok) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        reset_n_d = 1'b0;
        // A new request restarts the hold even on the completing edge.
        if (sw_rst_req) begin
          cnt_d       = '0;
          rst_cause_d = CAUSE_SW;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          reset_n_d  = 1'b1;
          rst_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        reset_n_d = 1'b1;
        if (sw_rst_req) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          reset_n_d   = 1'b0;
          rst_cause_d = CAUSE_SW;
        end
      end
      default: begin
        state_d   = S_ASSERT;
        cnt_d     = '0;
        reset_n_d = 1'b0;
      end
    endcase

    // Registered copy of the inverse so rst_active has no comb path.
    rst_active_d = ~reset_n_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_ASSERT;
      cnt_q        <= '0;
      reset_n_q    <= 1'b0;
      rst_active_q <= 1'b1;
      rst_done_q   <= 1'b0;
      rst_cause_q  <= CAUSE_HW;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reset_n_q    <= reset_n_d;
      rst_active_q <= rst_active_d;
      rst_done_q   <= rst_done_d;
      rst_cause_q  <= rst_cause_d;
    end
  end

  assign reset_n    = reset_n_q;
  assign rst_active = rst_active_q;
  assign rst_done   = rst_done_q;
  assign rst_cause  = rst_cause_q;

endmodule

// File: tb/tb_reset_gen_sync.sv
// tb_reset_gen_sync
// Drives two instances (defaults, and SYNC_STAGES=3/HOLD_CYCLES=1) with the
// same reset and request stimulus and compares them each cycle against an
// edge-counting reference: reset_n rises at a computed target edge, and any
// accepted software request moves the target to request_edge+HOLD_CYCLES.
module tb_reset_gen_sync;

  logic clk = 1'b0;
  logic reset;
  logic sw_rst_req;
  logic reset_n0, rst_active0, rst_done0, rst_cause0;
  logic reset_n1, rst_active1, rst_done1, rst_cause1;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = default instance, 1 = sweep instance.
  int m_edge[2];
  int m_rise[2];
  bit m_run[2];
  bit m_done[2];
  bit m_cause[2];

  always #5 clk = ~clk;

  reset_gen_sync #(.SYNC_STAGES(2), .HOLD_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .reset_n(reset_n0), .rst_active(rst_active0),
    .rst_done(rst_done0), .rst_cause(rst_cause0)
  );

  reset_gen_sync #(.SYNC_STAGES(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req),
    .reset_n(reset_n1), .rst_active(rst_active1),
    .rst_done(rst_done1), .rst_cause(rst_cause1)
  );

  function automatic int ss(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int hc(input int i);
    return (i == 0) ? 16 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_edge[i]  = 0;
      m_rise[i]  = ss(i) + hc(i) + 1;
      m_run[i]   = 1'b0;
      m_done[i]  = 1'b0;
      m_cause[i] = 1'b0;
    end
  endtask

  // One rising edge of the reference, sw = request level sampled at it.
  task automatic model_edge(input bit sw);
    for (int i = 0; i < 2; i++) begin
      m_edge[i]++;
      m_done[i] = 1'b0;
      if (!m_run[i]) begin
        // Edges after edge SYNC+1 are hold edges where requests count.
        if (sw && m_edge[i] >= ss(i) + 2) begin
          m_rise[i]  = m_edge[i] + hc(i);
          m_cause[i] = 1'b1;
        end
        if (m_edge[i] == m_rise[i]) begin
          m_run[i]  = 1'b1;
          m_done[i] = 1'b1;
        end
      end else if (sw) begin
        m_run[i]   = 1'b0;
        m_rise[i]  = m_edge[i] + hc(i);
        m_cause[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".reset_n0"},    reset_n0,    m_run[0]);
    chk({ph, ".rst_active0"}, rst_active0, !m_run[0]);
    chk({ph, ".rst_done0"},   rst_done0,   m_done[0]);
    chk({ph, ".rst_cause0"},  rst_cause0,  m_cause[0]);
    chk({ph, ".reset_n1"},    reset_n1,    m_run[1]);
    chk({ph, ".rst_active1"}, rst_active1, !m_run[1]);
    chk({ph, ".rst_done1"},   rst_done1,   m_done[1]);
    chk({ph, ".rst_cause1"},  rst_cause1,  m_cause[1]);
  endtask

  // Called at a falling edge; ends at the next falling edge after checking.
  task automatic cycle(input bit sw);
    sw_rst_req = sw;
    if (sw) $display("txn sw_rst_req edge=%0d t=%0t", m_edge[0] + 1, $time);
    @(posedge clk);
    if (!reset) model_edge(sw);
    @(negedge clk);
    check_all("cyc");
  endtask

  // Called at a falling edge; asserts reset between edges and checks the
  // outputs drop without any clock edge, then releases mid-cycle.
  task automatic hw_reset(input int n);
    $display("txn hw_reset cycles=%0d t=%0t", n, $time);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all("async");
    repeat (n) cycle(1'b0);
    #2 reset = 1'b0;
  endtask

  int rise0, rise1, low_cnt, done_cnt;

  initial begin
    reset      = 1'b1;
    sw_rst_req = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("por_reset");

    // Power-on: reset held 5 cycles, released mid-cycle.
    $display("txn power_on t=%0t", $time);
    repeat (5) cycle(1'b0);
    #2 reset = 1'b0;
    rise0 = -1;
    rise1 = -1;
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0);
      if (rise0 < 0 && reset_n0 === 1'b1) rise0 = m_edge[0];
      if (rise1 < 0 && reset_n1 === 1'b1) rise1 = m_edge[1];
    end
    chk("por_rise_edge0", rise0, 19);
    chk("por_rise_edge1", rise1, 5);

    // Single software request: reset_n low for exactly 16 cycles.
    low_cnt = 0;
    done_cnt = 0;
    cycle(1'b1);
    if (reset_n0 === 1'b0) low_cnt++;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0);
      if (reset_n0 === 1'b0) low_cnt++;
      if (rst_done0 === 1'b1) done_cnt++;
    end
    chk("sw_low_cycles", low_cnt, 16);
    chk("sw_done_pulses", done_cnt, 1);
    chk("sw_cause", rst_cause0, 1);

    // Re-request 5 cycles into the hold: one done pulse, 21 low cycles.
    low_cnt = 0;
    done_cnt = 0;
    cycle(1'b1);
    if (reset_n0 === 1'b0) low_cnt++;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0);
      if (reset_n0 === 1'b0) low_cnt++;
    end
    cycle(1'b1);
    if (reset_n0 === 1'b0) low_cnt++;
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0);
      if (reset_n0 === 1'b0) low_cnt++;
      if (rst_done0 === 1'b1) done_cnt++;
    end
    chk("rereq_low_cycles", low_cnt, 21);
    chk("rereq_done_pulses", done_cnt, 1);

    // Collision: request on the completing edge keeps the block in hold.
    done_cnt = 0;
    cycle(1'b1);
    repeat (15) cycle(1'b0);
    cycle(1'b1);
    chk("collide_still_low", reset_n0, 0);
    chk("collide_no_done", rst_done0, 0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0);
      if (rst_done0 === 1'b1) done_cnt++;
    end
    chk("collide_done_pulses", done_cnt, 1);

    // Async reset in the middle of a software hold.
    cycle(1'b1);
    repeat (5) cycle(1'b0);
    hw_reset(3);
    chk("async_cause", rst_cause0, 0);
    rise0 = -1;
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0);
      if (rise0 < 0 && reset_n0 === 1'b1) rise0 = m_edge[0];
    end
    chk("async_rise_edge0", rise0, 19);

    // Randomized requests and occasional board resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 149) == 0) hw_reset(int'($urandom_range(1, 4)));
      else cycle($urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
